systolic_array_controller_p: RTL and testbench

Parametrised successor to the fixed 5x5 systolic array controller. It sequences one matrix-multiply job on a ROWS x COLS output-stationary PE grid:
- clears the accumulators,
- generates skewed operand-feed enables for a runtime inner dimension k_len,
- captures the results,
- drains them one row per beat under a valid/ready handshake.

It sits between the job issuer (start/done) and the PE grid, operand feeders and result sink.

---
 rtl/systolic_array_controller_p.sv | 244 ++++++++++++++++++++++++
 tb/tb_systolic_array_controller_p.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_controller_p.sv
// ============================================================================
// systolic_array_controller_p
// ----------------------------------------------------------------------------
// Sequences one matrix-multiply job on a ROWS x COLS output-stationary PE grid:
// clears the accumulators while idle, generates skewed A/B operand-feed enables
// for a runtime inner dimension k_len, strobes a one-cycle result capture, then
// drains the results one row per beat under a valid/ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   job request, sampled in IDLE only
//   k_len      in   inner dimension (1..KMAX), sampled with start
//   abort      in   synchronous job cancel, ignored in IDLE
//   out_ready  in   result sink ready
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at job completion
//   start_err  out  one-cycle pulse after a rejected start
//   clr        out  per-PE accumulator clear, row-major (bit r*COLS+c)
//   a_feed_en  out  per-row A-operand valid
//   b_feed_en  out  per-column B-operand valid
//   read       out  per-PE capture strobe
//   write      out  per-PE output-register enable for the current drain row
//   out_valid  out  drain beat valid
//   out_row    out  row index of the current drain beat
//
// Every output decodes from registered state only (Moore machine); there is
// no combinational path from any input to any output.
// ============================================================================
module systolic_array_controller_p #(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int KMAX = 16,
    parameter int KW   = 5,
    parameter int CW   = 6,
    // Width of out_row; a single-row grid still needs a 1-bit index.
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 start_err,
    output logic [ROWS*COLS-1:0] clr,
    output logic [ROWS-1:0]      a_feed_en,
    output logic [COLS-1:0]      b_feed_en,
    output logic [ROWS*COLS-1:0] read,
    output logic [ROWS*COLS-1:0] write,
    output logic                 out_valid,
    output logic [RW-1:0]        out_row
);

    // One extra bit so that r + k never overflows in the feed-window compare.
    localparam int XW = CW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPUTE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row_nxt;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_nxt;
    logic          r_start_err;
    logic          w_start_err_nxt;

    logic          w_k_valid;
    logic [CW-1:0] w_last_cnt;
    logic          w_last_row;
    logic [XW-1:0] w_cnt_x;
    logic [XW-1:0] w_k_x;

    // ------------------------------------------------------------------------
    // Derived conditions
    // ------------------------------------------------------------------------
    assign w_k_valid  = (k_len != '0) && (k_len <= KW'(KMAX));

    // COMPUTE lasts T = k + ROWS + COLS - 2 cycles; the counter starts at 0,
    // so the final COMPUTE cycle is the one where the counter equals T-1.
    assign w_last_cnt = CW'(r_k) + CW'(ROWS + COLS - 2) - CW'(1);

    assign w_last_row = (r_row == RW'(ROWS - 1));
    assign w_cnt_x    = XW'(r_cnt);
    assign w_k_x      = XW'(r_k);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would create
    // order-dependent simulation and a mismatch with the synthesised flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_k         <= '0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_row       <= w_row_nxt;
            r_k         <= w_k_nxt;
            r_start_err <= w_start_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default
    // before the case statement; a path that leaves one unassigned would
    // infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;    // counter idles at 0 outside COMPUTE
        w_row_nxt       = '0;    // row index idles at 0 outside DRAIN
        w_k_nxt         = r_k;
        w_start_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_k_valid) begin
                        w_k_nxt     = k_len;
                        w_state_nxt = S_COMPUTE;
                    end else begin
                        w_start_err_nxt = 1'b1;
                    end
                end
            end

            S_COMPUTE: begin
                if (r_cnt == w_last_cnt) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_CAPTURE: begin
                w_state_nxt = S_DRAIN;
            end

            S_DRAIN: begin
                // out_valid is always high in DRAIN, so out_ready alone
                // completes the handshake.
                w_row_nxt = r_row;
                if (out_ready) begin
                    if (w_last_row) begin
                        w_state_nxt = S_DONE;
                        w_row_nxt   = '0;
                    end else begin
                        w_row_nxt = r_row + RW'(1);
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // abort overrides every transition above once a job is in flight.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_row_nxt   = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (registered state, counter, row and latched k only)
    // ------------------------------------------------------------------------
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        start_err = r_start_err;
        clr       = '0;
        a_feed_en = '0;
        b_feed_en = '0;
        read      = '0;
        write     = '0;
        out_valid = 1'b0;
        out_row   = r_row;

        case (r_state)
            S_IDLE: begin
                clr = '1;
            end

            S_COMPUTE: begin
                // Row r / column c receive operands on counter r..r+k-1 and
                // c..c+k-1: the diagonal skew of an output-stationary array.
                for (int r = 0; r < ROWS; r++) begin
                    a_feed_en[r] = (w_cnt_x >= XW'(r)) &&
                                   (w_cnt_x <  XW'(r) + w_k_x);
                end
                for (int c = 0; c < COLS; c++) begin
                    b_feed_en[c] = (w_cnt_x >= XW'(c)) &&
                                   (w_cnt_x <  XW'(c) + w_k_x);
                end
            end

            S_CAPTURE: begin
                read = '1;
            end

            S_DRAIN: begin
                out_valid = 1'b1;
                for (int r = 0; r < ROWS; r++) begin
                    if (RW'(r) == r_row) begin
                        write[r*COLS +: COLS] = '1;
                    end
                end
            end

            S_DONE: begin
                done = 1'b1;
            end

            default: begin
                clr = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_array_controller_p.sv
// ============================================================================
// tb_systolic_array_controller_p
// ----------------------------------------------------------------------------
// Two controller instances: a 5x5 grid (dut0) and a 4x8 grid (dut1). A
// job-level model derives the expected outputs of each instance from elapsed
// cycles since the accepted start, the drain beats handed over, and the
// abort/reset history. A single compare process checks every output of both
// instances on each falling edge. Directed jobs additionally check literal,
// hand-computed values (job lengths, feed-window snapshots, stall holds).
// ============================================================================
module tb_systolic_array_controller_p;

    localparam int R0   = 5;
    localparam int C0   = 5;
    localparam int R1   = 4;
    localparam int C1   = 8;
    localparam int KMAX = 16;
    localparam int KW   = 5;
    localparam int CW   = 6;
    localparam int HMAX = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_i [2];
    logic [KW-1:0] klen_i  [2];
    logic          abort_i [2];
    logic          ready_i [2];

    // dut0 (5x5) outputs
    logic        busy0, done0, serr0, ov0;
    logic [24:0] clr0, rd0, wr0;
    logic [4:0]  a0, b0;
    logic [2:0]  row0;
    // dut1 (4x8) outputs
    logic        busy1, done1, serr1, ov1;
    logic [31:0] clr1, rd1, wr1;
    logic [3:0]  a1;
    logic [7:0]  b1;
    logic [1:0]  row1;

    systolic_array_controller_p #(
        .ROWS(R0), .COLS(C0), .KMAX(KMAX), .KW(KW), .CW(CW)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .k_len(klen_i[0]),
        .abort(abort_i[0]), .out_ready(ready_i[0]), .busy(busy0), .done(done0),
        .start_err(serr0), .clr(clr0), .a_feed_en(a0), .b_feed_en(b0),
        .read(rd0), .write(wr0), .out_valid(ov0), .out_row(row0)
    );

    systolic_array_controller_p #(
        .ROWS(R1), .COLS(C1), .KMAX(KMAX), .KW(KW), .CW(CW)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .k_len(klen_i[1]),
        .abort(abort_i[1]), .out_ready(ready_i[1]), .busy(busy1), .done(done1),
        .start_err(serr1), .clr(clr1), .a_feed_en(a1), .b_feed_en(b1),
        .read(rd1), .write(wr1), .out_valid(ov1), .out_row(row1)
    );

    // Uniform 64-bit views so tasks can address either instance by index.
    logic [63:0] d_clr [2], d_a [2], d_b [2], d_rd [2], d_wr [2], d_row [2];
    logic        d_busy [2], d_done [2], d_serr [2], d_ov [2];

    assign d_clr[0] = 64'(clr0);  assign d_clr[1] = 64'(clr1);
    assign d_a[0]   = 64'(a0);    assign d_a[1]   = 64'(a1);
    assign d_b[0]   = 64'(b0);    assign d_b[1]   = 64'(b1);
    assign d_rd[0]  = 64'(rd0);   assign d_rd[1]  = 64'(rd1);
    assign d_wr[0]  = 64'(wr0);   assign d_wr[1]  = 64'(wr1);
    assign d_row[0] = 64'(row0);  assign d_row[1] = 64'(row1);
    assign d_busy[0] = busy0;     assign d_busy[1] = busy1;
    assign d_done[0] = done0;     assign d_done[1] = done1;
    assign d_serr[0] = serr0;     assign d_serr[1] = serr1;
    assign d_ov[0]   = ov0;       assign d_ov[1]   = ov1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int rows_of(input int id);
        return (id == 0) ? R0 : R1;
    endfunction

    function automatic int cols_of(input int id);
        return (id == 0) ? C0 : C1;
    endfunction

    function automatic logic [63:0] ones(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    // ------------------------------------------------------------------------
    // Job-level model
    //   m_act : a job is in flight
    //   m_t   : cycles elapsed since the accepting edge (1 = first compute
    //           cycle); T+1 is the capture cycle, T+2 means draining
    //   m_row : drain beats already handed over
    //   m_fin : last beat taken, completion cycle in progress
    // ------------------------------------------------------------------------
    bit m_act [2], m_fin [2], m_err [2];
    int m_k [2], m_t [2], m_row [2];

    typedef struct {
        logic [63:0] clr, a, b, rd, wr, row;
        logic        busy, done, serr, ov;
    } exp_t;

    always @(posedge clk) begin
        for (int id = 0; id < 2; id++) begin
            int t_len;
            t_len = m_k[id] + rows_of(id) + cols_of(id) - 2;
            if (!rst_n) begin
                m_act[id] = 0; m_fin[id] = 0; m_err[id] = 0;
                m_k[id] = 0;   m_t[id] = 0;   m_row[id] = 0;
            end else if (!m_act[id]) begin
                m_err[id] = start_i[id] &&
                            !(int'(klen_i[id]) >= 1 && int'(klen_i[id]) <= KMAX);
                if (start_i[id] && !m_err[id]) begin
                    m_act[id] = 1; m_fin[id] = 0;
                    m_k[id] = int'(klen_i[id]); m_t[id] = 1; m_row[id] = 0;
                end
            end else begin
                m_err[id] = 0;
                if (abort_i[id]) begin
                    m_act[id] = 0; m_fin[id] = 0; m_t[id] = 0; m_row[id] = 0;
                end else if (m_fin[id]) begin
                    m_act[id] = 0; m_fin[id] = 0; m_t[id] = 0;
                end else if (m_t[id] <= t_len + 1) begin
                    m_t[id]++;
                end else if (ready_i[id]) begin
                    if (m_row[id] == rows_of(id) - 1) begin
                        m_fin[id] = 1; m_row[id] = 0;
                    end else begin
                        m_row[id]++;
                    end
                end
            end
        end
    end

    function automatic exp_t model_out(input int id);
        exp_t e;
        int   nr, nc, t_len, cnt;
        nr = rows_of(id);
        nc = cols_of(id);
        e.clr = '0; e.a = '0; e.b = '0; e.rd = '0; e.wr = '0; e.row = '0;
        e.busy = 0; e.done = 0; e.serr = 0; e.ov = 0;
        if (!rst_n) begin
            e.clr = ones(nr * nc);
            return e;
        end
        e.serr = m_err[id];
        if (!m_act[id]) begin
            e.clr = ones(nr * nc);
            return e;
        end
        e.busy = 1;
        t_len  = m_k[id] + nr + nc - 2;
        if (m_fin[id]) begin
            e.done = 1;
        end else if (m_t[id] <= t_len) begin
            cnt = m_t[id] - 1;
            for (int r = 0; r < nr; r++)
                if (cnt >= r && cnt < r + m_k[id]) e.a[r] = 1'b1;
            for (int c = 0; c < nc; c++)
                if (cnt >= c && cnt < c + m_k[id]) e.b[c] = 1'b1;
        end else if (m_t[id] == t_len + 1) begin
            e.rd = ones(nr * nc);
        end else begin
            e.ov  = 1;
            e.row = 64'(m_row[id]);
            e.wr  = ones(nc) << (m_row[id] * nc);
        end
        return e;
    endfunction

    // Single compare process: every output of both instances, every cycle.
    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            exp_t e;
            e = model_out(id);
            check($sformatf("dut%0d busy", id),      64'(d_busy[id]), 64'(e.busy));
            check($sformatf("dut%0d done", id),      64'(d_done[id]), 64'(e.done));
            check($sformatf("dut%0d start_err", id), 64'(d_serr[id]), 64'(e.serr));
            check($sformatf("dut%0d clr", id),       d_clr[id],       e.clr);
            check($sformatf("dut%0d a_feed_en", id), d_a[id],         e.a);
            check($sformatf("dut%0d b_feed_en", id), d_b[id],         e.b);
            check($sformatf("dut%0d read", id),      d_rd[id],        e.rd);
            check($sformatf("dut%0d write", id),     d_wr[id],        e.wr);
            check($sformatf("dut%0d out_valid", id), 64'(d_ov[id]),   64'(e.ov));
            check($sformatf("dut%0d out_row", id),   d_row[id],       e.row);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    logic [63:0] hist_a [HMAX], hist_b [HMAX], hist_rd [HMAX], hist_wr [HMAX];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs a job from start to done. Cycle n (n=1 is the first compute cycle,
    // the start cycle is 0) snapshots go into hist_*. Optionally stalls the
    // sink on stall_row for stall_n cycles and pokes start (k_len=0) in cycle
    // poke_n to show it is ignored mid-job. exp_n is the expected done cycle.
    task automatic run_job(input int id, input int k, input int stall_row,
                           input int stall_n, input int poke_n,
                           input int exp_n, input string tag);
        int n, left;
        start_i[id] = 1'b1;
        klen_i[id]  = KW'(k);
        step();
        start_i[id] = 1'b0;
        n    = 1;
        left = stall_n;
        while (!d_done[id] && n < HMAX) begin
            hist_a[n] = d_a[id]; hist_b[n] = d_b[id];
            hist_rd[n] = d_rd[id]; hist_wr[n] = d_wr[id];
            start_i[id] = (n == poke_n);
            klen_i[id]  = (n == poke_n) ? '0 : KW'(k);
            if (d_ov[id] && d_row[id] == 64'(stall_row) && left > 0) begin
                ready_i[id] = 1'b0;
                left--;
                check({tag, " stall write"}, d_wr[id],
                      ones(cols_of(id)) << (stall_row * cols_of(id)));
            end else begin
                ready_i[id] = 1'b1;
            end
            step();
            n++;
        end
        start_i[id] = 1'b0;
        ready_i[id] = 1'b1;
        check({tag, " done cycle"}, 64'(n), 64'(exp_n));
        if (!d_done[id]) begin
            abort_i[id] = 1'b1;
            step();
            abort_i[id] = 1'b0;
        end
        step();
        check({tag, " idle after"}, 64'(d_busy[id]), 64'd0);
    endtask

    task automatic wait_row(input int id, input int row, input string tag);
        int n;
        n = 0;
        while (!(d_ov[id] && d_row[id] == 64'(row)) && n < 100) begin
            step();
            n++;
        end
        check({tag, " reached row"}, 64'(n < 100), 64'd1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        for (int id = 0; id < 2; id++) begin
            start_i[id] = 1'b0; klen_i[id] = '0;
            abort_i[id] = 1'b0; ready_i[id] = 1'b1;
        end
        step(2);
        check("reset clr0",  d_clr[0], 64'h1FF_FFFF);
        check("reset clr1",  d_clr[1], 64'hFFFF_FFFF);
        check("reset busy0", 64'(busy0), 64'd0);
        check("reset row0",  d_row[0], 64'd0);
        rst_n = 1'b1;
        step(2);

        // 5x5, k=5: T=13, capture in cycle 14, drain 15..19, done in 20.
        run_job(0, 5, -1, 0, -1, 20, "job5");
        check("job5 a@cnt0",  hist_a[1],  64'h01);
        check("job5 a@cnt4",  hist_a[5],  64'h1F);
        check("job5 a@cnt8",  hist_a[9],  64'h10);
        check("job5 b@cnt8",  hist_b[9],  64'h10);
        check("job5 a@cnt12", hist_a[13], 64'h00);
        check("job5 capture", hist_rd[14], 64'h1FF_FFFF);
        check("job5 row0 wr", hist_wr[15], 64'h1F);
        check("job5 row4 wr", hist_wr[19], 64'h1F0_0000);

        // Sink stalls 3 cycles on row 2: done slips to cycle 23.
        run_job(0, 5, 2, 3, -1, 23, "stall");

        // Rejected starts.
        start_i[0] = 1'b1; klen_i[0] = KW'(0);
        step();
        start_i[0] = 1'b0;
        check("k0 start_err", 64'(serr0), 64'd1);
        check("k0 busy",      64'(busy0), 64'd0);
        check("k0 clr",       d_clr[0],   64'h1FF_FFFF);
        step();
        check("k0 err pulse", 64'(serr0), 64'd0);
        start_i[0] = 1'b1; klen_i[0] = KW'(17);
        step();
        start_i[0] = 1'b0;
        check("k17 start_err", 64'(serr0), 64'd1);
        check("k17 busy",      64'(busy0), 64'd0);
        step(2);

        // Abort on compute counter 6 (a_feed_en = rows 2..4).
        start_i[0] = 1'b1; klen_i[0] = KW'(5);
        step();
        start_i[0] = 1'b0;
        step(6);
        check("abort a@cnt6", d_a[0], 64'h1C);
        abort_i[0] = 1'b1;
        step();
        abort_i[0] = 1'b0;
        check("abortC busy", 64'(busy0), 64'd0);
        check("abortC clr",  d_clr[0],   64'h1FF_FFFF);
        step(3);

        // Abort on drain row 3.
        start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        wait_row(0, 3, "abortD");
        abort_i[0] = 1'b1;
        step();
        abort_i[0] = 1'b0;
        check("abortD busy",  64'(busy0), 64'd0);
        check("abortD valid", 64'(ov0),   64'd0);
        check("abortD done",  64'(done0), 64'd0);
        step(2);
        run_job(0, 5, -1, 0, -1, 20, "after abort");

        // Start pokes during a job are ignored and do not stretch it.
        run_job(0, 5, -1, 0, 3, 20, "poke");

        // Asynchronous reset on drain row 1.
        start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        wait_row(0, 1, "rst");
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy",  64'(busy0), 64'd0);
        check("async rst clr",   d_clr[0],   64'h1FF_FFFF);
        check("async rst valid", 64'(ov0),   64'd0);
        check("async rst write", d_wr[0],    64'd0);
        check("async rst row",   d_row[0],   64'd0);
        step();
        rst_n = 1'b1;
        step();
        run_job(0, 5, -1, 0, -1, 20, "after rst");

        // 4x8, k=16: T=26, capture 27, drain 28..31, done in 32.
        run_job(1, 16, -1, 0, -1, 32, "job4x8");
        check("4x8 b7@cnt6",  hist_b[7]  & 64'h80, 64'h00);
        check("4x8 b7@cnt7",  hist_b[8]  & 64'h80, 64'h80);
        check("4x8 b7@cnt22", hist_b[23],          64'h80);
        check("4x8 b7@cnt23", hist_b[24],          64'h00);
        check("4x8 capture",  hist_rd[27],         64'hFFFF_FFFF);
        check("4x8 row3 wr",  hist_wr[31],         64'hFF00_0000);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
